// File: rtl/premcfilter_pkg.sv
// Shared constants, FSM state encoding and filter result type for the preMC
// horizontal high-pass filter.
package premcfilter_pkg;

  localparam int ROW_LEN = 144;
  localparam int HALF    = 8;
  localparam int TAPS    = 2 * HALF + 1;
  localparam int OUT_LEN = ROW_LEN - 2 * HALF;
  localparam int ROWS    = 144;
  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int SW      = 13;                 // holds 17 * 255 = 4335
  localparam int CW      = $clog2(TAPS + 1);
  localparam int BW      = $clog2(OUT_LEN);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_e;

  typedef logic signed [13:0] filt_t;

endpackage

// File: rtl/premcfilter_win17.sv
// 17-tap sliding window: tap shift register, running sum and the registered
// high-pass result y = 17*centre - sum.
module premcfilter_win17
  import premcfilter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] pix,
  output logic          produce,
  output filt_t         y_q
);

  logic [DW-1:0] shreg_q [TAPS];
  logic [DW-1:0] shreg_d [TAPS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [SW-1:0] prod;
  filt_t         y_d;

  // A push yields a result once the window holds all 17 pixels afterwards.
  assign produce = push && !clear && (cnt_q >= CW'(TAPS - 1));

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    y_d     = y_q;
    prod    = '0;
    if (clear) begin
      cnt_d = '0;
      sum_d = '0;
    end else if (push) begin
      shreg_d[0] = pix;
      for (int i = 1; i < TAPS; i++) shreg_d[i] = shreg_q[i-1];
      if (cnt_q == CW'(TAPS)) begin
        sum_d = sum_q + SW'(pix) - SW'(shreg_q[TAPS-1]);
      end else begin
        sum_d = sum_q + SW'(pix);
        cnt_d = cnt_q + CW'(1);
      end
      prod = SW'(shreg_d[HALF]) * SW'(TAPS);
      if (cnt_d == CW'(TAPS)) y_d = filt_t'({1'b0, prod}) - filt_t'({1'b0, sum_d});
    end
  end

  // NOTE: tap storage is deliberately not reset; the occupancy count and sum
  // are reset, and they gate every use of the taps.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sum_q <= '0;
      y_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      y_q   <= y_d;
    end
  end

endmodule

// File: rtl/premcfilter_hfilt.sv
// Reads one row from the image or template row buffer, high-pass filters it
// and streams OUT_LEN results per row over AXI-Stream with backpressure.
module premcfilter_hfilt
  import premcfilter_pkg::*;
(
  input  logic          s_axi_aclk,
  input  logic          s_axi_aresetn,
  input  logic          filter_begin,
  input  logic          template_mode,
  input  logic          frame_sync,
  output logic          img_rowbuf_rden,
  output logic          tml_rowbuf_rden,
  output logic [AW-1:0] rowbuf_rdaddr,
  input  logic [DW-1:0] img_rowbuf_rddata,
  input  logic [DW-1:0] tml_rowbuf_rddata,
  output logic [31:0]   m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          m_axis_tuser,
  output logic          row_done,
  output logic          frame_done,
  output logic          overrun
);

  state_e        state_q, state_d;
  logic          src_sel_q, src_sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_vld_q, rd_vld_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          tuser_q, tuser_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] row_cnt_q, row_cnt_d;
  logic          overrun_q, overrun_d;

  logic          adv, issue, rd_en, push, produce, hs_last, win_clear;
  logic [DW-1:0] pix;
  filt_t         y;

  // The whole read/filter pipeline moves only when the output slot can take a beat.
  assign adv       = ~tvalid_q | m_axis_tready;
  assign issue     = (state_q != IDLE) && (addr_q < AW'(ROW_LEN));
  assign rd_en     = issue && adv;
  assign push      = rd_vld_q && adv;
  assign hs_last   = tvalid_q && tlast_q && m_axis_tready;
  assign win_clear = (state_q == IDLE) && filter_begin;
  assign pix       = src_sel_q ? tml_rowbuf_rddata : img_rowbuf_rddata;

  premcfilter_win17 u_win (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .clear   (win_clear),
    .push    (push),
    .pix     (pix),
    .produce (produce),
    .y_q     (y)
  );

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    src_sel_d = src_sel_q;
    addr_d    = addr_q;
    rd_vld_d  = adv ? rd_en : rd_vld_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    beat_d    = beat_q;
    row_cnt_d = frame_sync ? '0 : row_cnt_q;
    overrun_d = frame_sync ? 1'b0 : overrun_q;

    if (filter_begin && state_q != IDLE) overrun_d = 1'b1;
    if (rd_en) addr_d = addr_q + AW'(1);

    case (state_q)
      IDLE: if (filter_begin) begin
        state_d   = FILL;
        src_sel_d = template_mode;
        addr_d    = '0;
        beat_d    = '0;
      end
      FILL: if (rd_en && addr_q == AW'(2 * HALF - 1)) state_d = RUN;
      RUN:  if (hs_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (adv) begin
      tvalid_d = produce;
      tlast_d  = produce && (beat_q == BW'(OUT_LEN - 1));
      tuser_d  = produce && (beat_q == '0) && (row_cnt_q == '0);
      if (produce) beat_d = beat_q + BW'(1);
    end

    // frame_sync has already been folded into row_cnt_d above.
    if (hs_last) row_cnt_d = (row_cnt_d == AW'(ROWS - 1)) ? '0 : row_cnt_d + AW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      src_sel_q <= 1'b0;
      addr_q    <= '0;
      rd_vld_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      beat_q    <= '0;
      row_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_sel_q <= src_sel_d;
      addr_q    <= addr_d;
      rd_vld_q  <= rd_vld_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      beat_q    <= beat_d;
      row_cnt_q <= row_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign img_rowbuf_rden = rd_en && !src_sel_q;
  assign tml_rowbuf_rden = rd_en && src_sel_q;
  assign rowbuf_rdaddr   = issue ? addr_q : '0;
  assign m_axis_tdata    = {16'h0000, {2{y[13]}}, y};
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tuser    = tuser_q;
  assign row_done        = hs_last;
  assign frame_done      = hs_last && !frame_sync && (row_cnt_q == AW'(ROWS - 1));
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_premcfilter_hfilt.sv
// Self-checking bench for premcfilter_hfilt: a row-level arithmetic model
// checked against every output beat, plus directed literal checks.
module tb_premcfilter_hfilt;

  localparam int ROW_LEN = 144;
  localparam int HALF    = 8;
  localparam int OUT_LEN = 128;
  localparam int ROWS    = 144;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        filter_begin = 1'b0;
  logic        template_mode = 1'b0;
  logic        frame_sync = 1'b0;
  logic        img_rden, tml_rden;
  logic [7:0]  rdaddr;
  logic [7:0]  img_rddata = 8'h00;
  logic [7:0]  tml_rddata = 8'h00;
  logic [31:0] tdata;
  logic        tvalid, tlast, tuser;
  logic        tready = 1'b1;
  logic        row_done, frame_done, overrun;

  always #5 clk = ~clk;

  premcfilter_hfilt dut (
    .s_axi_aclk        (clk),
    .s_axi_aresetn     (rst_n),
    .filter_begin      (filter_begin),
    .template_mode     (template_mode),
    .frame_sync        (frame_sync),
    .img_rowbuf_rden   (img_rden),
    .tml_rowbuf_rden   (tml_rden),
    .rowbuf_rdaddr     (rdaddr),
    .img_rowbuf_rddata (img_rddata),
    .tml_rowbuf_rddata (tml_rddata),
    .m_axis_tdata      (tdata),
    .m_axis_tvalid     (tvalid),
    .m_axis_tready     (tready),
    .m_axis_tlast      (tlast),
    .m_axis_tuser      (tuser),
    .row_done          (row_done),
    .frame_done        (frame_done),
    .overrun           (overrun)
  );

  logic [7:0] img_mem [ROW_LEN];
  logic [7:0] tml_mem [ROW_LEN];

  // Row buffers: one-cycle read latency, data held while rden is low.
  always @(posedge clk) begin
    if (img_rden) img_rddata <= img_mem[rdaddr];
    if (tml_rden) tml_rddata <= tml_mem[rdaddr];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  int          exp_y [OUT_LEN];
  logic [31:0] got_y [OUT_LEN];
  int          rdy_mode = 0;

  function automatic logic [7:0] pat(input int p, input int i);
    case (p)
      0:       return 8'd100;
      1:       return (i == 72) ? 8'd255 : 8'd0;
      2:       return 8'(i * 37 + 11);
      3:       return 8'($urandom);
      default: return 8'(i * 11) ^ 8'h5A;
    endcase
  endfunction

  task automatic load(input int p_img, input int p_tml);
    for (int i = 0; i < ROW_LEN; i++) begin
      img_mem[i] = pat(p_img, i);
      tml_mem[i] = pat(p_tml, i);
    end
  endtask

  // y[k] = 17 * p[k+HALF] - sum(p[k .. k+2*HALF])
  task automatic build_model(input bit tm);
    for (int k = 0; k < OUT_LEN; k++) begin
      int s;
      s = 0;
      for (int j = 0; j <= 2 * HALF; j++) s += int'(tm ? tml_mem[k+j] : img_mem[k+j]);
      exp_y[k] = 17 * int'(tm ? tml_mem[k+HALF] : img_mem[k+HALF]) - s;
    end
  endtask

  // tready: held high, toggling, or random; changes 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int          beat_idx = 0;
  int          model_row = 0;
  int          fd_cnt = 0;
  int          tuser_cnt = 0;
  logic        stall_pend = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last, stall_user;

  // Compare process: every beat against the model, plus hold-while-stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      beat_idx   = 0;
      model_row  = 0;
      stall_pend = 1'b0;
    end else begin
      if (frame_sync) model_row = 0;
      if (stall_pend) begin
        check("stall_tvalid", 32'(tvalid), 32'(1));
        check("stall_tdata", tdata, stall_data);
        check("stall_tlast_tuser", {30'b0, tlast, tuser}, {30'b0, stall_last, stall_user});
      end
      stall_pend = tvalid && !tready;
      stall_data = tdata;
      stall_last = tlast;
      stall_user = tuser;
      if (tvalid && tready) begin
        if (beat_idx >= OUT_LEN) begin
          n_checks++;
          n_err++;
          $display("FAIL beat_count: beat %0d beyond row length %0d", beat_idx, OUT_LEN);
        end else begin
          check("tdata", tdata, {16'h0000, 16'(exp_y[beat_idx])});
          got_y[beat_idx] = tdata;
          check("tlast", 32'(tlast), 32'(beat_idx == OUT_LEN - 1));
          check("tuser", 32'(tuser), 32'(beat_idx == 0 && model_row == 0));
        end
        check("row_done", 32'(row_done), 32'(beat_idx == OUT_LEN - 1));
        check("frame_done", 32'(frame_done), 32'(beat_idx == OUT_LEN - 1 && model_row == ROWS - 1));
        if (tuser) tuser_cnt++;
        if (frame_done) fd_cnt++;
        if (beat_idx == OUT_LEN - 1) begin
          beat_idx  = 0;
          model_row = (model_row == ROWS - 1) ? 0 : model_row + 1;
        end else begin
          beat_idx++;
        end
      end else begin
        check("row_done_idle", 32'(row_done), 32'(0));
        check("frame_done_idle", 32'(frame_done), 32'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one row. ovr_n / fs_n: cycle to pulse filter_begin / frame_sync mid-row.
  // rst_hs: assert reset after that many handshakes (0 = never).
  task automatic run_row(input bit tm, input bit sync, input int ovr_n, input int fs_n,
                         input int rst_hs, input bit chk_lat);
    int n, first_v, last_v, hs, wrong_rd, seen_rd;
    bit done;
    build_model(tm);
    tick();
    filter_begin  = 1'b1;
    template_mode = tm;
    frame_sync    = sync;
    tick();
    filter_begin  = 1'b0;
    frame_sync    = 1'b0;
    template_mode = ~tm;
    n = 1; first_v = 0; last_v = 0; hs = 0; wrong_rd = 0; seen_rd = 0; done = 0;
    check("first_read_en", 32'(tm ? tml_rden : img_rden), 32'(1));
    check("first_read_addr", 32'(rdaddr), 32'(0));
    while (!done && n < 4000) begin
      if (tm ? img_rden : tml_rden) wrong_rd++;
      if (tm ? tml_rden : img_rden) seen_rd++;
      if (tvalid && first_v == 0) first_v = n;
      if (tvalid && tlast && last_v == 0) last_v = n;
      if (tvalid && tready) hs++;
      if (row_done) done = 1;
      filter_begin = (n == ovr_n);
      frame_sync   = (n == fs_n);
      if (rst_hs > 0 && hs == rst_hs) begin
        rst_n = 1'b0;
        #1;
        check("reset_tvalid", 32'(tvalid), 32'(0));
        check("reset_rden", {30'b0, img_rden, tml_rden}, 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("after_reset_idle", {29'b0, tvalid, img_rden, tml_rden}, 32'(0));
        return;
      end
      tick();
      n++;
    end
    filter_begin = 1'b0;
    frame_sync   = 1'b0;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL row_timeout: no row_done within %0d cycles", n);
    end
    @(negedge clk);
    #1;
    check("beats_per_row", 32'(hs), 32'(OUT_LEN));
    check("reads_per_row", 32'(seen_rd), 32'(ROW_LEN));
    check("wrong_src_reads", 32'(wrong_rd), 32'(0));
    if (chk_lat) begin
      check("first_tvalid_cycle", 32'(first_v), 32'(19));
      check("tlast_cycle", 32'(last_v), 32'(146));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, tu0;
    rst_n = 1'b0;
    tick();
    check("reset_outputs", {23'b0, img_rden, tml_rden, tvalid, tlast, tuser, row_done,
                            frame_done, overrun, 1'b0}, 32'(0));
    check("reset_tdata", tdata, 32'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // 1: constant row -> all zero
    load(0, 4);
    rdy_mode = 0;
    run_row(0, 1, 0, 0, 0, 1);
    check("const_beat0", got_y[0], 32'h0000_0000);
    check("const_beat127", got_y[127], 32'h0000_0000);

    // 2: impulse at pixel 72
    load(1, 4);
    run_row(0, 0, 0, 0, 0, 1);
    check("model_impulse_peak", 32'(exp_y[64]), 32'(4080));
    check("impulse_peak", got_y[64], 32'h0000_0FF0);
    check("impulse_left_edge", got_y[56], 32'h0000_FF01);
    check("impulse_right_edge", got_y[72], 32'h0000_FF01);
    check("impulse_outside_l", got_y[55], 32'h0000_0000);
    check("impulse_outside_r", got_y[73], 32'h0000_0000);

    // 3: sawtooth ramp under toggling and random backpressure
    load(2, 4);
    rdy_mode = 1;
    run_row(0, 0, 0, 0, 0, 0);
    rdy_mode = 2;
    run_row(0, 0, 0, 0, 0, 0);
    rdy_mode = 0;

    // 4: template source
    load(2, 4);
    run_row(1, 0, 0, 0, 0, 1);

    // 5: full frame of random rows, then one more to see row 0 again
    fd0 = fd_cnt;
    tu0 = tuser_cnt;
    for (int r = 0; r < ROWS; r++) begin
      load(3, 3);
      run_row(1'(r % 2), r == 0, 0, 0, 0, 0);
    end
    check("frame_done_count", 32'(fd_cnt - fd0), 32'(1));
    check("tuser_per_frame", 32'(tuser_cnt - tu0), 32'(1));
    load(3, 4);
    run_row(0, 0, 0, 0, 0, 0);
    check("tuser_after_wrap", 32'(tuser_cnt - tu0), 32'(2));

    // 6: overrun, frame_sync mid-row, reset mid-row
    load(2, 4);
    run_row(0, 0, 40, 0, 0, 1);
    check("overrun_set", 32'(overrun), 32'(1));
    tick();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'(0));
    run_row(0, 0, 0, 60, 0, 0);
    load(3, 4);
    run_row(0, 0, 0, 0, 0, 0);
    run_row(0, 0, 0, 0, 50, 0);
    load(2, 4);
    run_row(0, 0, 0, 0, 0, 1);
    check("row0_after_reset", got_y[0], {16'h0000, 16'(exp_y[0])});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
